machine_dispatch: RTL and testbench

//  Owns the 320-bit pending table that machine_service updates combinationally. Registers it each cycle.

---
 rtl/machine_dispatch_pkg.sv | 54 +++++
 rtl/machine_dispatch_if.sv | 28 ++
 rtl/machine_dispatch_slot_pick.sv | 23 ++
 rtl/machine_dispatch.sv | 136 +++++++++++++
 tb/tb_machine_dispatch.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/machine_dispatch_pkg.sv
// Shared types for the dispatch block: tag encodings, slot layout of the 320-bit
// pending table, FSM states and small slot-field helpers.
package machine_types;

  localparam int NARROW_W  = 65;
  localparam int WIDE_W    = 95;
  localparam int NUM_SLOTS = 4;
  localparam int TABLE_W   = 2 * NARROW_W + 2 * WIDE_W;
  localparam int PAYLOAD_W = WIDE_W - 2;

  typedef logic [1:0]           tag_t;
  typedef logic [TABLE_W-1:0]   table_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  localparam tag_t TAG_EMPTY  = 2'b00;
  localparam tag_t TAG_QUEUED = 2'b01;
  localparam tag_t TAG_BUSY   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Slot 0 sits at the top of the table: [319:255] [254:190] [189:95] [94:0].
  function automatic tag_t get_tag(input table_t t, input logic [1:0] idx);
    case (idx)
      2'd0:    get_tag = t[319:318];
      2'd1:    get_tag = t[254:253];
      2'd2:    get_tag = t[189:188];
      default: get_tag = t[94:93];
    endcase
  endfunction

  function automatic payload_t get_payload(input table_t t, input logic [1:0] idx);
    case (idx)
      2'd0:    get_payload = {{(PAYLOAD_W - NARROW_W + 2){1'b0}}, t[317:255]};
      2'd1:    get_payload = {{(PAYLOAD_W - NARROW_W + 2){1'b0}}, t[252:190]};
      2'd2:    get_payload = t[187:95];
      default: get_payload = t[92:0];
    endcase
  endfunction

  function automatic table_t set_tag(input table_t t, input logic [1:0] idx, input tag_t tag);
    set_tag = t;
    case (idx)
      2'd0:    set_tag[319:318] = tag;
      2'd1:    set_tag[254:253] = tag;
      2'd2:    set_tag[189:188] = tag;
      default: set_tag[94:93]   = tag;
    endcase
  endfunction

endpackage

// File: rtl/machine_dispatch_if.sv
// Issue channel between the dispatcher (master) and the reducer (slave):
// valid/ready request plus the reducer's completion pulse.
interface machine_dispatch_if;
  import machine_types::*;

  logic     issue_vld;
  logic     issue_rdy;
  logic [1:0] issue_slot;
  payload_t issue_data;
  logic     done;

  modport master (
    output issue_vld,
    output issue_slot,
    output issue_data,
    input  issue_rdy,
    input  done
  );

  modport slave (
    input  issue_vld,
    input  issue_slot,
    input  issue_data,
    output issue_rdy,
    output done
  );

endinterface

// File: rtl/machine_dispatch_slot_pick.sv
// Combinational fixed-priority picker: lowest-index slot whose tag is QUEUED.
// Busy and illegal tags are never selected.
module machine_slot_pick
  import machine_types::*;
(
  input  logic [NUM_SLOTS-1:0][1:0] tags,
  output logic                      found,
  output logic [1:0]                idx
);

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (tags[i] == TAG_QUEUED) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/machine_dispatch.sv
// Pending-table register and single-outstanding issue FSM.
// Optional watchdog on the WAIT state is enabled by MACHINE_DISPATCH_TIMEOUT_EN.
module machine_dispatch
  import machine_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [TABLE_W-1:0] svc_result,
  output logic [TABLE_W-1:0] pending,
  machine_dispatch_if.master iss,
  output logic [2:0]        occupancy,
  output logic              timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog (1..255)");
  end

  state_t     state_q, state_d;
  table_t     pending_q, pending_d;
  logic       vld_q, vld_d;
  logic [1:0] slot_q, slot_d;
  payload_t   data_q, data_d;
  logic       tmo_q, tmo_d;

  logic [NUM_SLOTS-1:0][1:0] tags;
  logic                      pick_found;
  logic [1:0]                pick_idx;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_tags
    assign tags[gi] = get_tag(pending_q, 2'(gi));
  end

  machine_slot_pick u_pick (
    .tags  (tags),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MACHINE_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = svc_result;
    vld_d     = vld_q;
    slot_d    = slot_q;
    data_d    = data_q;
    tmo_d     = 1'b0;
`ifdef MACHINE_DISPATCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          slot_d  = pick_idx;
          data_d  = get_payload(pending_q, pick_idx);
          vld_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Tag override beats svc_result for the latched slot; payload is untouched.
        if (iss.issue_rdy) begin
          pending_d = set_tag(svc_result, slot_q, TAG_BUSY);
          vld_d     = 1'b0;
          state_d   = ST_WAIT;
`ifdef MACHINE_DISPATCH_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      ST_WAIT: begin
        if (iss.done) begin
          pending_d = set_tag(svc_result, slot_q, TAG_EMPTY);
          state_d   = ST_IDLE;
        end
`ifdef MACHINE_DISPATCH_TIMEOUT_EN
        else if (cnt_q == TMO_LIMIT) begin
          pending_d = set_tag(svc_result, slot_q, TAG_EMPTY);
          tmo_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      vld_q     <= 1'b0;
      slot_q    <= 2'd0;
      data_q    <= '0;
      tmo_q     <= 1'b0;
`ifdef MACHINE_DISPATCH_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      vld_q     <= vld_d;
      slot_q    <= slot_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
`ifdef MACHINE_DISPATCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    occupancy = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupancy = occupancy + {2'b00, (tags[i] != TAG_EMPTY)};
    end
  end

  assign pending        = pending_q;
  assign iss.issue_vld  = vld_q;
  assign iss.issue_slot = slot_q;
  assign iss.issue_data = data_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_machine_dispatch.sv
// Directed bench for machine_dispatch; models machine_service as a feedback of
// pending with one-cycle request injections. Watchdog cases need MACHINE_DISPATCH_TIMEOUT_EN.
module tb_machine_dispatch;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [319:0] svc;
  logic [319:0] pending;
  logic [2:0]   occupancy;
  logic         timeout_err;
  logic [3:0]   req_en = 4'b0;
  logic [94:0]  req_val [4];

  int checks = 0;
  int errors = 0;

  machine_dispatch_if dif ();

  machine_dispatch #(.TIMEOUT_CYCLES(4)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .svc_result     (svc),
    .pending        (pending),
    .iss            (dif),
    .occupancy      (occupancy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Upstream model: keep the table as is, except for slots written this cycle.
  always_comb begin
    svc = pending;
    if (req_en[0]) svc[319:255] = req_val[0][64:0];
    if (req_en[1]) svc[254:190] = req_val[1][64:0];
    if (req_en[2]) svc[189:95]  = req_val[2];
    if (req_en[3]) svc[94:0]    = req_val[3];
  end

  function automatic logic [1:0] tag_of(input logic [319:0] t, input int s);
    case (s)
      0:       tag_of = t[319:318];
      1:       tag_of = t[254:253];
      2:       tag_of = t[189:188];
      default: tag_of = t[94:93];
    endcase
  endfunction

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic queue(input int s, input logic [92:0] p);
    if (s < 2) req_val[s] = {30'b0, 2'b01, p[62:0]};
    else       req_val[s] = {2'b01, p};
    req_en[s] = 1'b1;
  endtask

  task automatic issue_expect(input string tag, input logic [1:0] s, input logic [92:0] d);
    check({tag, "_vld"},  320'(dif.issue_vld), 320'(1'b1));
    check({tag, "_slot"}, 320'(dif.issue_slot), 320'(s));
    check({tag, "_data"}, 320'(dif.issue_data), 320'(d));
  endtask

  task automatic handshake();
    dif.issue_rdy = 1'b1;
    tick();
    dif.issue_rdy = 1'b0;
  endtask

  task automatic pulse_done();
    dif.done = 1'b1;
    tick();
    dif.done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [92:0] full_pl;
    int          pulses;
    int          pulse_at;
    full_pl = 93'h1_0123_4567_89AB_CDEF_FEDC_BA9;
    for (int i = 0; i < 4; i++) req_val[i] = '0;
    dif.issue_rdy = 1'b0;
    dif.done      = 1'b0;

    // 1. reset
    tick();
    tick();
    check("rst_pending", pending, 320'd0);
    check("rst_vld", 320'(dif.issue_vld), 320'd0);
    check("rst_slot", 320'(dif.issue_slot), 320'd0);
    check("rst_data", 320'(dif.issue_data), 320'd0);
    check("rst_occ", 320'(occupancy), 320'd0);
    check("rst_tmo", 320'(timeout_err), 320'd0);
    rst = 1'b0;
    tick();

    // 2. single request in slot 1
    queue(1, 93'h5);
    tick();
    req_en = 4'b0;
    check("t2_occ", 320'(occupancy), 320'd1);
    check("t2_latency", 320'(dif.issue_vld), 320'd0);
    tick();
    issue_expect("t2", 2'd1, 93'h5);
    handshake();
    check("t2_busy", 320'(tag_of(pending, 1)), 320'(2'b10));
    check("t2_vld_wait", 320'(dif.issue_vld), 320'd0);
    tick();
    tick();
    check("t2_still_busy", 320'(tag_of(pending, 1)), 320'(2'b10));
    pulse_done();
    check("t2_freed", 320'(tag_of(pending, 1)), 320'd0);
    check("t2_occ_end", 320'(occupancy), 320'd0);

    // 3. slots 0 and 3 together: index priority, then full-width payload
    queue(0, 93'h1234);
    queue(3, full_pl);
    tick();
    req_en = 4'b0;
    check("t3_occ", 320'(occupancy), 320'd2);
    tick();
    issue_expect("t3a", 2'd0, 93'h1234);
    handshake();
    check("t3_busy0", 320'(tag_of(pending, 0)), 320'(2'b10));
    check("t3_q3", 320'(tag_of(pending, 3)), 320'(2'b01));
    pulse_done();
    check("t3_free0", 320'(tag_of(pending, 0)), 320'd0);
    check("t3_gap", 320'(dif.issue_vld), 320'd0);
    tick();
    issue_expect("t3b", 2'd3, full_pl);
    handshake();
    pulse_done();
    check("t3_occ_end", 320'(occupancy), 320'd0);

    // 4. back-pressure with a second request arriving during ISSUE
    queue(0, 93'h77);
    tick();
    req_en = 4'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) queue(2, 93'h2222);
      tick();
      req_en = 4'b0;
      check("t4_hold", {dif.issue_vld, dif.issue_slot, dif.issue_data},
            320'({1'b1, 2'd0, 93'h77}));
    end
    check("t4_q2_occ", 320'(occupancy), 320'd2);
    handshake();
    check("t4_q2_waiting", 320'(tag_of(pending, 2)), 320'(2'b01));
    check("t4_vld_wait", 320'(dif.issue_vld), 320'd0);
    pulse_done();
    tick();
    issue_expect("t4b", 2'd2, 93'h2222);
    handshake();
    check("t4_busy2", 320'(tag_of(pending, 2)), 320'(2'b10));

    // 5. reset while in WAIT, then a stale done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_pending", pending, 320'd0);
    check("t5_vld", 320'(dif.issue_vld), 320'd0);
    check("t5_occ", 320'(occupancy), 320'd0);
    tick();
    pulse_done();
    check("t5_stale_done", pending, 320'd0);
    queue(3, 93'h3);
    tick();
    req_en = 4'b0;
    tick();
    issue_expect("t5_idle", 2'd3, 93'h3);
    handshake();
    pulse_done();
    check("t5_occ_end", 320'(occupancy), 320'd0);

`ifdef MACHINE_DISPATCH_TIMEOUT_EN
    // 6a. withhold done: expiry after TIMEOUT_CYCLES+1 WAIT cycles
    queue(1, 93'h9);
    tick();
    req_en = 4'b0;
    tick();
    handshake();
    pulses   = 0;
    pulse_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (timeout_err === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    check("t6_pulses", 320'(pulses), 320'd1);
    check("t6_pulse_time", 320'(pulse_at), 320'd5);
    check("t6_freed", 320'(tag_of(pending, 1)), 320'd0);
    queue(0, 93'h44);
    tick();
    req_en = 4'b0;
    tick();
    issue_expect("t6_idle", 2'd0, 93'h44);

    // 6b. done on the expiry cycle wins
    handshake();
    for (int i = 0; i < 4; i++) tick();
    pulse_done();
    check("t6b_tmo", 320'(timeout_err), 320'd0);
    check("t6b_freed", 320'(tag_of(pending, 0)), 320'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (timeout_err === 1'b1) pulses++;
    end
    check("t6b_pulses", 320'(pulses), 320'd0);
`else
    // Without the watchdog, WAIT holds indefinitely.
    queue(1, 93'h9);
    tick();
    req_en = 4'b0;
    tick();
    handshake();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timeout_err !== 1'b0) pulses++;
    end
    check("nowd_pulses", 320'(pulses), 320'd0);
    check("nowd_busy", 320'(tag_of(pending, 1)), 320'(2'b10));
    pulse_done();
    check("nowd_freed", 320'(tag_of(pending, 1)), 320'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
